// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, access size codes, sticky error cause bits and the helper
// that folds the data-port controls into a single request.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_t;

  // Access size codes. On a read (fetch or load) the code 00 means a
  // full word; on a write it carries the store width.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Sticky error cause bits; err is the OR of all of them.
  localparam int ERR_W            = 3;
  localparam int ERR_RW_CONFLICT  = 0;  // d_read and d_write together
  localparam int ERR_TIMEOUT      = 1;  // memory never acknowledged
  localparam int ERR_SPURIOUS_ACK = 2;  // mem_ack with nothing in flight

  // A data-port access is pending on a load or on any sized store.
  function automatic logic data_req(input logic rd, input logic [1:0] wr);
    return rd | (wr != SZ_NONE);
  endfunction

endpackage

// File: rtl/arb_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once the count reaches MAX it holds until cleared.
module arb_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: clear, else saturating increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch
// port and the data port of the pipeline.
//
// Handshake: a requester holds its request level (if_req, or d_read /
// d_write) until it sees the matching one-cycle done pulse; the request
// is consumed at the grant edge and the requester may change or drop it
// in the done cycle. Towards memory, mem_req is held high with stable
// address/data/we/size until a single-cycle mem_ack, whose cycle also
// carries valid mem_rdata. A transaction that sees no ack within TIMEOUT
// cycles is abandoned and reported done with zero read data.
//
// In a requester's own done cycle it is masked from being granted, but
// it keeps its place in the priority order: if it still requests and
// would have won, nobody is granted that cycle. The other requester is
// granted in the done cycle only when it actually wins arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_read,
  input  logic [1:0]        d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err,
  output logic [1:0]        state_dbg,
  output logic [ERR_W-1:0]  err_cause
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  arb_state_t          state, state_next;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo_count;

  logic d_dreq;
  logic starved;
  logic want_if, want_d;
  logic grant_if, grant_d;
  logic complete, abort;
  logic tmo_hit;
  logic streak_clr, streak_inc;
  logic tmo_clr, tmo_inc;

  assign d_dreq  = data_req(d_read, d_write);
  assign starved = (streak == STREAK_W'(STARVE_LIMIT));
  assign tmo_hit = (tmo_count == TMO_W'(TIMEOUT));

  // Priority winner among raw requests: data first, unless the fetch
  // port has been passed over STARVE_LIMIT times in a row.
  assign want_if = if_req & (~d_dreq | starved);
  assign want_d  = d_dreq & (~if_req | ~starved);

  assign stall     = (if_req & ~if_done) | (d_dreq & ~d_done);
  assign err       = |err_cause;
  assign state_dbg = state;

  // Streak of data grants taken while fetch was waiting.
  assign streak_clr = grant_if | ~if_req;
  assign streak_inc = grant_d & if_req;

  arb_counter #(.W(STREAK_W), .MAX(STARVE_LIMIT)) u_streak (
    .clk   (clk),
    .rst   (rst),
    .clr   (streak_clr),
    .inc   (streak_inc),
    .count (streak)
  );

  // Cycles spent waiting for mem_ack in the current transaction.
  assign tmo_clr = grant_if | grant_d;
  assign tmo_inc = (state != IDLE);

  arb_counter #(.W(TMO_W), .MAX(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmo_clr),
    .inc   (tmo_inc),
    .count (tmo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state plus grant / completion / abort strobes.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (want_if && !if_done) begin
          grant_if   = 1'b1;
          state_next = IF_BUSY;
        end else if (want_d && !d_done) begin
          grant_d    = 1'b1;
          state_next = D_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request registers, returned data, done pulses and
  // sticky error causes. Address and data hold their last value in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= SZ_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err_cause <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;

      if (grant_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_size <= SZ_NONE;
        mem_addr <= if_addr;
      end else if (grant_d) begin
        // A store wins over a simultaneous load; d_write is the size.
        mem_req   <= 1'b1;
        mem_we    <= (d_write != SZ_NONE);
        mem_size  <= d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end

      if (complete || abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == IF_BUSY) begin
          if_done  <= 1'b1;
          if_rdata <= complete ? mem_rdata : '0;
        end else begin
          d_done  <= 1'b1;
          d_rdata <= complete ? mem_rdata : '0;
        end
      end

      if (d_read && (d_write != SZ_NONE)) begin
        err_cause[ERR_RW_CONFLICT] <= 1'b1;
      end
      if (abort) begin
        err_cause[ERR_TIMEOUT] <= 1'b1;
      end
      if ((state == IDLE) && mem_ack) begin
        err_cause[ERR_SPURIOUS_ACK] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction-fetch port (pc/instruction) and data port (MemREAD/MemWrite/Read_data_2/data).
- Sequences each access as a request/ack transaction and drives a stall to the pipeline while any port is unserved.
- Sits between the CPU core and the external memory model/SRAM wrapper inside the chip top.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum back-to-back data grants allowed while fetch is waiting.
- TIMEOUT, 255, cycles to wait for mem_ack before aborting a transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request (level).
- if_addr  in  ADDR_W  fetch address (pc).
- if_rdata  out  DATA_W  fetched instruction.
- if_done  out  1  one-cycle pulse: fetch complete.
- d_read  in  1  data read request (MemREAD).
- d_write  in  2  data write size: 00 none, 01 byte, 10 half, 11 word.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data (Read_data_2).
- d_rdata  out  DATA_W  load data.
- d_done  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write enable.
- mem_size  out  2  access size: 00 word for reads, otherwise d_write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.
- stall  out  1  pipeline hold.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; streak counter and timeout counter cleared.
  - mem_req, mem_we, if_done, d_done and err are 0; mem_size=00; all address and data outputs are 0.
  - Reset mid-transaction drops mem_req immediately; the aborted access is never reported done.
- Data request: d_dreq = d_read | (d_write != 00). If d_read and d_write are both active, the write wins and err is set.
- FSM states:
  - IDLE: sample the requests.
    - If both are pending, data wins unless streak == STARVE_LIMIT, in which case fetch wins.
    - On grant, register the address, data, we and size, assert mem_req next cycle, and go to IF_BUSY or D_BUSY.
  - IF_BUSY / D_BUSY: mem_req held with stable outputs. The timeout counter increments each cycle.
    - On mem_ack, capture mem_rdata into if_rdata or d_rdata, pulse the matching done in the next cycle, drop mem_req, and go to IDLE.
    - If the counter reaches TIMEOUT with no ack, set err, pulse done with rdata=0, and go to IDLE.
- Done cycle: the requester just served is masked from arbitration during its done cycle, so it can update or drop its request. The other requester may be granted in that same cycle.
- Minimum transaction latency: grant edge → mem_req in cycle t+1. An ack in cycle t+1 gives done in t+2. Back-to-back throughput is one access per 3 cycles with a zero-wait memory.
- Streak counter:
  - Increments on each data grant made while if_req is pending.
  - Clears on any fetch grant, or when if_req is low.
  - Saturates at STARVE_LIMIT.
- stall = (if_req & ~if_done) | (d_dreq & ~d_done). Combinational. Asserted in the request cycle and deasserted in the done cycle.
- Timeout counter clears on every grant.
- mem_ack while in IDLE is ignored and sets err.
- Address and data outputs hold their last value in IDLE.
- err clears only on reset.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE/IF_BUSY/D_BUSY.
  - size constants SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD.
  - the err cause bit definitions.
- One natural sub-module: arb_counter, a saturating up-counter with clear, instantiated twice (streak with width clog2(STARVE_LIMIT+1), timeout with width clog2(TIMEOUT+1)).

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0040, memory acks 1 cycle after mem_req with 0x0013_0093 → mem_addr=0x40, mem_we=0, if_done pulses 1 cycle with if_rdata=0x0013_0093, stall low in the done cycle.
- Simultaneous: if_req and d_write=11 with d_addr=0x100, d_wdata=0xDEAD_BEEF → data granted first (mem_we=1, mem_size=11, mem_wdata=0xDEADBEEF), then fetch, with stall high until both dones.
- Starvation: if_req held and d_read re-asserted after every d_done → exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
- Timeout: TIMEOUT=8 and d_read with mem_ack never asserted → done pulse at cycle 9 after mem_req rises, d_rdata=0, err=1 and stays 1.
- Reset mid-operation: drop rst while in D_BUSY → mem_req=0 in the same cycle, no d_done, state IDLE, and a new request after rst=1 is served normally.
- Illegal request: d_read=1 and d_write=10 together → write of size 10 issued, err=1.
